// File: rtl/arm_data_mem_arbiter.sv
// Data-RAM arbiter between the single-cycle ARM core and a DMA/loader port.
// The core has priority; a saturating wait counter forces a DMA grant after MaxWait denials.
module arm_data_mem_arbiter #(
   parameter int BusWidth = 32,
   parameter int MaxWait  = 4
) (
   input  logic                i_CLK,
   input  logic                i_RESET,
   input  logic                i_CPU_Req,
   input  logic                i_CPU_Write_Enable,
   input  logic [BusWidth-1:0] i_CPU_Address,
   input  logic [BusWidth-1:0] i_CPU_Write_Data,
   output logic [BusWidth-1:0] o_CPU_Read_Data,
   output logic                o_CPU_Stall,
   input  logic                i_DMA_Req,
   input  logic                i_DMA_Write_Enable,
   input  logic [BusWidth-1:0] i_DMA_Address,
   input  logic [BusWidth-1:0] i_DMA_Write_Data,
   output logic                o_DMA_Ack,
   output logic [BusWidth-1:0] o_DMA_Read_Data,
   output logic                o_DMA_Valid,
   output logic                o_Mem_Write_Enable,
   output logic [BusWidth-1:0] o_Mem_Address,
   output logic [BusWidth-1:0] o_Mem_Write_Data,
   input  logic [BusWidth-1:0] i_Mem_Read_Data
);
   localparam int CW = $clog2(MaxWait + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MaxWait);

   typedef enum logic {CPU_PRIO, DMA_FORCE} state_t;

   state_t        state;
   logic [CW-1:0] wait_cnt;
   logic [CW-1:0] wait_inc;
   logic          dma_own;
   logic          cpu_own;

   // In DMA_FORCE a pending DMA request wins over the core; otherwise the core wins.
   always_comb begin
      dma_own  = i_RESET && i_DMA_Req && (state == DMA_FORCE || !i_CPU_Req);
      cpu_own  = i_RESET && i_CPU_Req && !dma_own;
      wait_inc = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
   end

   assign o_DMA_Ack          = dma_own;
   assign o_CPU_Stall        = i_RESET && i_CPU_Req && dma_own;
   assign o_Mem_Address      = dma_own ? i_DMA_Address    : i_CPU_Address;
   assign o_Mem_Write_Data   = dma_own ? i_DMA_Write_Data : i_CPU_Write_Data;
   assign o_Mem_Write_Enable = dma_own ? i_DMA_Write_Enable : (cpu_own && i_CPU_Write_Enable);
   assign o_CPU_Read_Data    = i_Mem_Read_Data;

   always_ff @(posedge i_CLK) begin
      if (!i_RESET) begin
         state           <= CPU_PRIO;
         wait_cnt        <= '0;
         o_DMA_Valid     <= 1'b0;
         o_DMA_Read_Data <= '0;
      end else begin
         o_DMA_Valid <= dma_own && !i_DMA_Write_Enable;
         if (dma_own && !i_DMA_Write_Enable)
            o_DMA_Read_Data <= i_Mem_Read_Data;
         // A denied request accumulates priority; a grant or a dropped request clears it.
         if (i_DMA_Req && !dma_own) begin
            wait_cnt <= wait_inc;
            state    <= (wait_inc == WAIT_MAX) ? DMA_FORCE : CPU_PRIO;
         end else begin
            wait_cnt <= '0;
            state    <= CPU_PRIO;
         end
      end
   end
endmodule

// File: tb/tb_arm_data_mem_arbiter.sv
// Directed + random bench for arm_data_mem_arbiter against a grant/denial-count reference model.
module tb_arm_data_mem_arbiter;
   localparam int W    = 32;
   localparam int MAXW = 4;

   logic         clk = 1'b0;
   logic         rst_n, cpu_req, cpu_we, dma_req, dma_we;
   logic [W-1:0] cpu_addr, cpu_wd, dma_addr, dma_wd;
   logic [W-1:0] cpu_rd, dma_rd, mem_addr, mem_wd, mem_rd;
   logic         stall, ack, dma_vld, mem_we;

   arm_data_mem_arbiter #(.BusWidth(W), .MaxWait(MAXW)) dut (
      .i_CLK(clk), .i_RESET(rst_n),
      .i_CPU_Req(cpu_req), .i_CPU_Write_Enable(cpu_we), .i_CPU_Address(cpu_addr),
      .i_CPU_Write_Data(cpu_wd), .o_CPU_Read_Data(cpu_rd), .o_CPU_Stall(stall),
      .i_DMA_Req(dma_req), .i_DMA_Write_Enable(dma_we), .i_DMA_Address(dma_addr),
      .i_DMA_Write_Data(dma_wd), .o_DMA_Ack(ack), .o_DMA_Read_Data(dma_rd),
      .o_DMA_Valid(dma_vld), .o_Mem_Write_Enable(mem_we), .o_Mem_Address(mem_addr),
      .o_Mem_Write_Data(mem_wd), .i_Mem_Read_Data(mem_rd)
   );

   always #5 clk = ~clk;

   // Environment RAM: written only through the DUT's memory port.
   logic [W-1:0] ram [64];
   assign mem_rd = ram[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wd;

   // Reference model state
   logic [W-1:0] mmem [64];
   int           denied;
   logic         m_vld;
   logic [W-1:0] m_rd;
   logic         last_ack, last_stall;
   int           checks = 0, fails = 0;

   task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      assert (act === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, act, exp);
      end
   endtask

   // One clock cycle: inputs already set by the caller just after a rising edge.
   task automatic step();
      logic         g, we;
      logic [W-1:0] a, wd;
      #2;
      g  = rst_n && dma_req && (!cpu_req || denied >= MAXW);
      a  = g ? dma_addr : cpu_addr;
      wd = g ? dma_wd : cpu_wd;
      we = rst_n && (g ? dma_we : (cpu_req && cpu_we));
      chk("dma_ack", {31'b0, ack}, {31'b0, g});
      chk("cpu_stall", {31'b0, stall}, {31'b0, g && cpu_req});
      chk("mem_we", {31'b0, mem_we}, {31'b0, we});
      if (rst_n) begin
         chk("mem_addr", mem_addr, a);
         chk("cpu_rdata", cpu_rd, mmem[a[7:2]]);
         if (we) chk("mem_wdata", mem_wd, wd);
      end
      last_ack   = g;
      last_stall = g && cpu_req;
      @(posedge clk);
      if (!rst_n) begin
         denied = 0; m_vld = 1'b0; m_rd = '0;
      end else begin
         m_vld = g && !dma_we;
         if (m_vld) m_rd = mmem[dma_addr[7:2]];
         if (we) mmem[a[7:2]] = wd;
         if (dma_req && !g) denied = (denied + 1 > MAXW) ? MAXW : denied + 1;
         else denied = 0;
      end
      #1;
      chk("dma_valid", {31'b0, dma_vld}, {31'b0, m_vld});
      chk("dma_rdata", dma_rd, m_rd);
   endtask

   task automatic set_cpu(input logic r, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
      cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wd = d;
   endtask

   task automatic set_dma(input logic r, input logic w, input logic [W-1:0] a, input logic [W-1:0] d);
      dma_req = r; dma_we = w; dma_addr = a; dma_wd = d;
   endtask

   int acks;

   initial begin
      for (int i = 0; i < 64; i++) begin ram[i] = '0; mmem[i] = '0; end
      denied = 0; m_vld = 1'b0; m_rd = '0;
      @(posedge clk); #1;

      // Reset with both requesters active
      rst_n = 1'b0;
      set_cpu(1, 1, 32'h4, 32'h11);
      set_dma(1, 1, 32'h8, 32'h22);
      repeat (3) step();
      rst_n = 1'b1;
      set_cpu(1, 0, 32'h4, 0);
      step();
      chk("post_reset_cpu_first", {31'b0, last_ack}, 32'h0);

      // DMA-only write then read
      set_cpu(0, 0, 0, 0);
      set_dma(1, 1, 32'h10, 32'hDEADBEEF);
      step();
      chk("dma_wr_ack", {31'b0, last_ack}, 32'h1);
      set_dma(1, 0, 32'h10, 0);
      step();
      chk("dma_rd_value", dma_rd, 32'hDEADBEEF);
      chk("dma_rd_valid", {31'b0, dma_vld}, 32'h1);

      // Starvation limit
      set_cpu(1, 0, 32'h0, 0);
      acks = 0;
      repeat (4) begin step(); acks += int'(last_ack); end
      chk("starve_no_ack", acks, 0);
      step();
      chk("starve_forced_ack", {30'b0, last_ack, last_stall}, 32'h3);
      set_dma(0, 0, 0, 0);
      step();
      chk("starve_cpu_back", {31'b0, last_stall}, 32'h0);

      // Dropped request forfeits priority
      set_dma(1, 0, 32'h10, 0);
      repeat (4) step();
      set_dma(0, 0, 0, 0);
      step();
      chk("drop_no_ack", {30'b0, last_ack, last_stall}, 32'h0);
      set_dma(1, 0, 32'h10, 0);
      acks = 0;
      repeat (4) begin step(); acks += int'(last_ack); end
      chk("drop_rewait", acks, 0);
      step();
      chk("drop_then_ack", {31'b0, last_ack}, 32'h1);

      // Reset mid-wait
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      acks = 0;
      repeat (4) begin step(); acks += int'(last_ack); end
      chk("rst_midwait_rewait", acks, 0);
      step();
      chk("rst_midwait_ack", {31'b0, last_ack}, 32'h1);

      // CPU store followed by forced DMA read of the same word
      set_dma(1, 0, 32'h20, 0);
      repeat (3) step();
      set_cpu(1, 1, 32'h20, 32'h5);
      step();
      set_cpu(1, 0, 32'h24, 0);
      step();
      chk("hazard_rdata", dma_rd, 32'h5);

      // Random traffic with a DMA that honours the handshake
      set_dma(0, 0, 0, 0);
      for (int n = 0; n < 400; n++) begin
         rst_n = ($urandom_range(0, 60) != 0);
         set_cpu($urandom_range(0, 3) != 0, $urandom_range(0, 1), {24'b0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
         if (!dma_req && $urandom_range(0, 1))
            set_dma(1, $urandom_range(0, 1), {24'b0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
         step();
         if (last_ack) dma_req = 1'b0;
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule
